// File: rtl/otter_ex_operand_stage.sv
// Execute-stage operand register for the OTTER pipeline.
// Holds one decoded instruction and resolves its register operands with
// MEM/WB forwarding. It selects the ALU operand sources and counts the
// cycles it spends back-pressured.
module otter_ex_operand_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  // decode side
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [31:0]            id_rs1_data,
  input  logic [31:0]            id_rs2_data,
  input  logic [31:0]            id_imm,
  input  logic [31:0]            id_pc,
  input  logic [4:0]             id_rs1_addr,
  input  logic [4:0]             id_rs2_addr,
  input  logic [4:0]             id_rd_addr,
  input  logic                   id_reg_write,
  input  logic                   id_srcA_sel,
  input  logic [1:0]             id_srcB_sel,
  input  logic [3:0]             id_alu_fun,
  // forwarding sources
  input  logic                   mem_reg_write,
  input  logic [4:0]             mem_rd_addr,
  input  logic [31:0]            mem_result,
  input  logic                   wb_reg_write,
  input  logic [4:0]             wb_rd_addr,
  input  logic [31:0]            wb_result,
  // control
  input  logic                   flush,
  // execute side
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [3:0]             alu_fun,
  output logic [31:0]            ex_rs2,
  output logic [4:0]             ex_rd_addr,
  output logic                   ex_reg_write,
  output logic [31:0]            ex_pc,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

  logic                   valid_reg;
  logic [31:0]            rs1_data_reg;
  logic [31:0]            rs2_data_reg;
  logic [31:0]            imm_reg;
  logic [31:0]            pc_reg;
  logic [4:0]             rs1_addr_reg;
  logic [4:0]             rs2_addr_reg;
  logic [4:0]             rd_addr_reg;
  logic                   reg_write_reg;
  logic                   src_a_sel_reg;
  logic [1:0]             src_b_sel_reg;
  logic [3:0]             alu_fun_reg;
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  logic                   capture;
  logic                   stalled;
  logic [31:0]            rs1_fwd;
  logic [31:0]            rs2_fwd;

  // The slot is free when it is empty or its occupant leaves this cycle.
  assign id_ready = !valid_reg || ex_ready;
  assign capture  = id_valid && id_ready && !flush;
  assign stalled  = valid_reg && !ex_ready;

  // Occupancy: flush beats capture; an accepted occupant leaves unless it is replaced.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_reg <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (capture) begin
      valid_reg <= 1'b1;
    end else if (ex_ready) begin
      valid_reg <= 1'b0;
    end
  end

  // Instruction fields load only on capture, so they stay frozen during a stall.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rs1_data_reg  <= '0;
      rs2_data_reg  <= '0;
      imm_reg       <= '0;
      pc_reg        <= '0;
      rs1_addr_reg  <= '0;
      rs2_addr_reg  <= '0;
      rd_addr_reg   <= '0;
      reg_write_reg <= 1'b0;
      src_a_sel_reg <= 1'b0;
      src_b_sel_reg <= '0;
      alu_fun_reg   <= '0;
    end else if (capture) begin
      rs1_data_reg  <= id_rs1_data;
      rs2_data_reg  <= id_rs2_data;
      imm_reg       <= id_imm;
      pc_reg        <= id_pc;
      rs1_addr_reg  <= id_rs1_addr;
      rs2_addr_reg  <= id_rs2_addr;
      rd_addr_reg   <= id_rd_addr;
      reg_write_reg <= id_reg_write;
      src_a_sel_reg <= id_srcA_sel;
      src_b_sel_reg <= id_srcB_sel;
      alu_fun_reg   <= id_alu_fun;
    end
  end

  // Back-pressure cycle counter, stops at all ones instead of wrapping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_reg <= '0;
    end else if (stalled && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
    end
  end

  // Forwarding from the held entry: WB is applied first so that MEM, the
  // younger result, overrides it. Register x0 is never forwarded.
  always_comb begin
    rs1_fwd = rs1_data_reg;
    rs2_fwd = rs2_data_reg;
    if (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == rs1_addr_reg)) begin
      rs1_fwd = wb_result;
    end
    if (mem_reg_write && (mem_rd_addr != 5'd0) && (mem_rd_addr == rs1_addr_reg)) begin
      rs1_fwd = mem_result;
    end
    if (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == rs2_addr_reg)) begin
      rs2_fwd = wb_result;
    end
    if (mem_reg_write && (mem_rd_addr != 5'd0) && (mem_rd_addr == rs2_addr_reg)) begin
      rs2_fwd = mem_result;
    end
  end

  // ALU operand source selection.
  always_comb begin
    alu_a = src_a_sel_reg ? pc_reg : rs1_fwd;
    alu_b = rs2_fwd;
    case (src_b_sel_reg)
      2'b00:   alu_b = rs2_fwd;
      2'b01:   alu_b = imm_reg;
      2'b10:   alu_b = 32'd4;
      default: alu_b = 32'd0;
    endcase
  end

  assign ex_valid     = valid_reg;
  assign alu_fun      = alu_fun_reg;
  assign ex_rs2       = rs2_fwd;
  assign ex_rd_addr   = rd_addr_reg;
  assign ex_reg_write = reg_write_reg;
  assign ex_pc        = pc_reg;
  assign stall_cnt    = stall_cnt_reg;

endmodule

// File: tb/tb_otter_ex_operand_stage.sv
// Self-checking bench for otter_ex_operand_stage: a transaction-level model
// checked on every falling edge, plus literal checks for the directed vectors.
module tb_otter_ex_operand_stage;

  localparam int W       = 4;
  localparam int CNT_MAX = (1 << W) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [31:0] id_rs1_data = '0, id_rs2_data = '0, id_imm = '0, id_pc = '0;
  logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
  logic        id_reg_write = 1'b0, id_srcA_sel = 1'b0;
  logic [1:0]  id_srcB_sel = '0;
  logic [3:0]  id_alu_fun = '0;
  logic        mem_reg_write = 1'b0, wb_reg_write = 1'b0;
  logic [4:0]  mem_rd_addr = '0, wb_rd_addr = '0;
  logic [31:0] mem_result = '0, wb_result = '0;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [31:0] alu_a, alu_b, ex_rs2, ex_pc;
  logic [3:0]  alu_fun;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;
  logic [W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  otter_ex_operand_stage #(.STALL_CNT_W(W)) dut (
    .CLK(clk), .RST_N(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_reg_write(id_reg_write), .id_srcA_sel(id_srcA_sel), .id_srcB_sel(id_srcB_sel),
    .id_alu_fun(id_alu_fun),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .ex_rs2(ex_rs2),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_pc(ex_pc),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        v;
    logic [31:0] rs1, rs2, imm, pc;
    logic [4:0]  a1, a2, rd;
    logic        rw, sa;
    logic [1:0]  sb;
    logic [3:0]  fun;
  } entry_t;

  entry_t m;
  int     m_cnt = 0;

  function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] held);
    if (addr == 0) return held;
    if (mem_reg_write && mem_rd_addr == addr) return mem_result;
    if (wb_reg_write && wb_rd_addr == addr) return wb_result;
    return held;
  endfunction

  function automatic logic [31:0] exp_b();
    case (m.sb)
      2'b00:   return fwd(m.a2, m.rs2);
      2'b01:   return m.imm;
      2'b10:   return 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  // Model state advances on each rising edge; reset clears it at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m = '{default: '0};
      m_cnt = 0;
    end else begin
      if (m.v && !ex_ready && m_cnt < CNT_MAX) m_cnt++;
      if (flush) m.v = 1'b0;
      else if (id_valid && (!m.v || ex_ready))
        m = '{1'b1, id_rs1_data, id_rs2_data, id_imm, id_pc, id_rs1_addr, id_rs2_addr,
              id_rd_addr, id_reg_write, id_srcA_sel, id_srcB_sel, id_alu_fun};
      else if (ex_ready) m.v = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(ex_valid), 0);
      chk("rst_cnt", 32'(stall_cnt), 0);
      chk("rst_a", alu_a, 0);
      chk("rst_b", alu_b, 0);
      chk("rst_fun", 32'(alu_fun), 0);
      chk("rst_rs2", ex_rs2, 0);
      chk("rst_rd", 32'({ex_reg_write, ex_rd_addr}), 0);
      chk("rst_pc", ex_pc, 0);
    end else begin
      chk("m_id_ready", 32'(id_ready), 32'(!m.v || ex_ready));
      chk("m_ex_valid", 32'(ex_valid), 32'(m.v));
      chk("m_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      if (m.v) begin
        chk("m_alu_a", alu_a, m.sa ? m.pc : fwd(m.a1, m.rs1));
        chk("m_alu_b", alu_b, exp_b());
        chk("m_alu_fun", 32'(alu_fun), 32'(m.fun));
        chk("m_ex_rs2", ex_rs2, fwd(m.a2, m.rs2));
        chk("m_rd", 32'({ex_reg_write, ex_rd_addr}), 32'({m.rw, m.rd}));
        chk("m_pc", ex_pc, m.pc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] r1d, input logic [31:0] r2d, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] rd, input logic rw, input logic sa,
                       input logic [1:0] sb, input logic [3:0] fun);
    id_valid = 1'b1;
    id_rs1_data = r1d; id_rs2_data = r2d; id_imm = imm; id_pc = pc;
    id_rs1_addr = a1; id_rs2_addr = a2; id_rd_addr = rd;
    id_reg_write = rw; id_srcA_sel = sa; id_srcB_sel = sb; id_alu_fun = fun;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    step(); step();
    chk("reset_id_ready", 32'(id_ready), 1);
    rst_n = 1'b1;
    step();

    // capture / drain
    ex_ready = 1'b1;
    offer(32'd5, 32'd7, 32'h20, 32'h100, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 2'b00, 4'b0000);
    step();
    id_valid = 1'b0;
    chk("cap_valid", 32'(ex_valid), 1);
    chk("cap_alu_a", alu_a, 32'd5);
    chk("cap_alu_b", alu_b, 32'd7);
    chk("cap_fun", 32'(alu_fun), 0);
    step();
    chk("drain_valid", 32'(ex_valid), 0);
    $display("txn capture/drain done");

    // stall: A held, B offered for 3 back-pressured cycles
    ex_ready = 1'b0;
    offer(32'h11, 32'h22, 32'h0, 32'h200, 5'd9, 5'd10, 5'd5, 1'b1, 1'b0, 2'b00, 4'd3);
    step();
    offer(32'h33, 32'h44, 32'h0, 32'h204, 5'd11, 5'd12, 5'd6, 1'b1, 1'b0, 2'b00, 4'd4);
    #1;
    chk("stall_id_ready", 32'(id_ready), 0);
    chk("stall_cnt0", 32'(stall_cnt), 0);
    step(); step(); step();
    chk("stall_cnt3", 32'(stall_cnt), 3);
    chk("stall_frozen_a", alu_a, 32'h11);
    ex_ready = 1'b1;
    step();
    id_valid = 1'b0;
    chk("after_stall_a", alu_a, 32'h33);
    $display("txn stall done");

    // forwarding priority on C
    offer(32'h1111, 32'h2222, 32'h0, 32'h300, 5'd3, 5'd3, 5'd8, 1'b1, 1'b0, 2'b00, 4'd1);
    step();
    id_valid = 1'b0; ex_ready = 1'b0;
    mem_reg_write = 1'b1; mem_rd_addr = 5'd3; mem_result = 32'hAAAA;
    wb_reg_write = 1'b1;  wb_rd_addr = 5'd3;  wb_result = 32'hBBBB;
    #1;
    chk("fwd_mem_a", alu_a, 32'hAAAA);
    chk("fwd_mem_b", alu_b, 32'hAAAA);
    mem_reg_write = 1'b0;
    #1;
    chk("fwd_wb_a", alu_a, 32'hBBBB);
    // D reads x0, which must never forward; srcB = constant 4
    ex_ready = 1'b1;
    mem_reg_write = 1'b1; mem_rd_addr = 5'd0;
    offer(32'h1234, 32'h5678, 32'h0, 32'h304, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 2'b10, 4'd2);
    step();
    id_valid = 1'b0; ex_ready = 1'b0; wb_rd_addr = 5'd0;
    #1;
    chk("fwd_x0_a", alu_a, 32'h1234);
    chk("const4_b", alu_b, 32'd4);
    chk("x0_rs2", ex_rs2, 32'h5678);
    $display("txn forwarding done");

    // flush beats capture
    step();
    ex_ready = 1'b1; flush = 1'b1;
    offer(32'hDEAD, 32'hBEEF, 32'h0, 32'h308, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0, 2'b00, 4'd5);
    #1;
    chk("flush_id_ready", 32'(id_ready), 1);
    step();
    flush = 1'b0; id_valid = 1'b0;
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_nocap", 32'(alu_a == 32'hDEAD), 0);
    step();
    chk("flush_still_empty", 32'(ex_valid), 0);
    $display("txn flush done");

    // saturation: F held for 20 stalled cycles; pc source, zero source, fun 1111
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    ex_ready = 1'b0;
    offer(32'h5, 32'h6, 32'h0, 32'h400, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 2'b11, 4'hF);
    step();
    id_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", 32'(stall_cnt), 32'd15);
    chk("pc_src_a", alu_a, 32'h400);
    chk("zero_src_b", alu_b, 32'd0);
    chk("fun_pass", 32'(alu_fun), 32'hF);
    // asynchronous reset mid-stall, checked before any clock edge
    rst_n = 1'b0;
    #2;
    chk("async_valid", 32'(ex_valid), 0);
    chk("async_cnt", 32'(stall_cnt), 0);
    chk("async_fun", 32'(alu_fun), 0);
    step();
    rst_n = 1'b1;
    chk("post_rst_ready", 32'(id_ready), 1);
    ex_ready = 1'b1;
    offer(32'h99, 32'h1, 32'h77, 32'h500, 5'd2, 5'd3, 5'd2, 1'b1, 1'b0, 2'b01, 4'd0);
    step();
    id_valid = 1'b0;
    chk("post_rst_cap", 32'(ex_valid), 1);
    chk("post_rst_imm", alu_b, 32'h77);
    step();
    chk("post_rst_drain", 32'(ex_valid), 0);
    $display("txn saturation/reset done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
